// File: rtl/sumador_arbiter_2req_pkg.sv
// Shared types and constants for the two-requester add/sub arbiter.
// Default build wraps on overflow; define SUMADOR_ARB_SAT_EN to saturate instead.
package sumador_arbiter_2req_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam logic [15:0] SAT_POS = 16'h7FFF;
  localparam logic [15:0] SAT_NEG = 16'h8000;

  // Returns the winning requester id (0 or 1); ties go to whoever was not served last.
  function automatic logic pick_winner(input logic i_req0, input logic i_req1,
                                       input logic i_last);
    return (i_req0 && i_req1) ? ~i_last : i_req1;
  endfunction

endpackage

// File: rtl/sumador_16bits.sv
// Combinational two's-complement adder/subtractor with signed overflow flag.
module sumador_16bits
  import sumador_arbiter_2req_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_ctrl,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_overflow
);

  logic [WIDTH-1:0] w_b_eff;
  logic [WIDTH-1:0] w_carry_in;

  always_comb begin
    w_b_eff    = (i_ctrl == OP_SUB) ? ~i_b : i_b;
    w_carry_in = {{(WIDTH-1){1'b0}}, (i_ctrl == OP_SUB)};
    o_sum      = i_a + w_b_eff + w_carry_in;
    // Same rule covers add and subtract once b is conditionally inverted.
    o_overflow = (i_a[WIDTH-1] == w_b_eff[WIDTH-1]) && (o_sum[WIDTH-1] != i_a[WIDTH-1]);
  end

endmodule

// File: rtl/sumador_arbiter_2req.sv
// Round-robin arbiter sharing one add/sub datapath between two requesters.
// Optional SUMADOR_ARB_SAT_EN: saturate the registered result on signed overflow.
module sumador_arbiter_2req
  import sumador_arbiter_2req_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             ctrl0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             req1,
  input  logic             ctrl1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             busy,
  output logic             grant_id
);

  state_e           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_ctrl;
  logic             r_last;
  logic             r_grant;
  logic             r_done0;
  logic             r_done1;
  logic             r_busy;
  logic [WIDTH-1:0] r_result;
  logic             r_overflow;

  logic             w_win;
  logic [WIDTH-1:0] w_sum;
  logic             w_ovf;
  logic [WIDTH-1:0] w_res;

  assign w_win = pick_winner(req0, req1, r_last);

  sumador_16bits #(
    .WIDTH (WIDTH)
  ) u_datapath (
    .i_a        (r_a),
    .i_b        (r_b),
    .i_ctrl     (r_ctrl),
    .o_sum      (w_sum),
    .o_overflow (w_ovf)
  );

`ifdef SUMADOR_ARB_SAT_EN
  // On overflow the true result carries the sign of a; at WIDTH=16 these are SAT_NEG/SAT_POS.
  always_comb begin
    w_res = w_sum;
    if (w_ovf) begin
      w_res = r_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end
`else
  assign w_res = w_sum;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_a        <= '0;
      r_b        <= '0;
      r_ctrl     <= OP_ADD;
      r_last     <= 1'b1;
      r_grant    <= 1'b0;
      r_done0    <= 1'b0;
      r_done1    <= 1'b0;
      r_busy     <= 1'b0;
      r_result   <= '0;
      r_overflow <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (req0 || req1) begin
            r_grant <= w_win;
            r_last  <= w_win;
            r_a     <= w_win ? a1 : a0;
            r_b     <= w_win ? b1 : b0;
            r_ctrl  <= w_win ? ctrl1 : ctrl0;
            r_busy  <= 1'b1;
            r_state <= EXEC;
          end
        end
        EXEC: begin
          r_result   <= w_res;
          r_overflow <= w_ovf;
          r_done0    <= ~r_grant;
          r_done1    <= r_grant;
          r_state    <= DONE;
        end
        DONE: begin
          r_done0 <= 1'b0;
          r_done1 <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign done0    = r_done0;
  assign done1    = r_done1;
  assign result   = r_result;
  assign overflow = r_overflow;
  assign busy     = r_busy;
  assign grant_id = r_grant;

endmodule

// File: tb/tb_sumador_arbiter_2req.sv
// Directed self-checking bench for sumador_arbiter_2req (either SUMADOR_ARB_SAT_EN build).
module tb_sumador_arbiter_2req;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 1'b0, ctrl0 = 1'b0, req1 = 1'b0, ctrl1 = 1'b0;
  logic [15:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic        done0, done1, overflow, busy, grant_id;
  logic [15:0] result;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sumador_arbiter_2req #(
    .WIDTH (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req0     (req0),
    .ctrl0    (ctrl0),
    .a0       (a0),
    .b0       (b0),
    .req1     (req1),
    .ctrl1    (ctrl1),
    .a1       (a1),
    .b1       (b1),
    .done0    (done0),
    .done1    (done1),
    .result   (result),
    .overflow (overflow),
    .busy     (busy),
    .grant_id (grant_id)
  );

  // {busy, grant_id, done0, done1}
  wire [3:0] st = {busy, grant_id, done0, done1};

  // Arithmetic table: requester, a, b, ctrl, expected result, expected overflow
  localparam int NV = 6;
  localparam logic        VSEL [NV] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  localparam logic [15:0] VA   [NV] = '{16'h0005, 16'h8000, 16'h7FFF, 16'h0003, 16'h8000, 16'h7FFF};
  localparam logic [15:0] VB   [NV] = '{16'h0003, 16'h0001, 16'h0001, 16'h0005, 16'h8000, 16'hFFFF};
  localparam logic        VC   [NV] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`ifdef SUMADOR_ARB_SAT_EN
  localparam logic [15:0] VR   [NV] = '{16'h0008, 16'h8000, 16'h7FFF, 16'hFFFE, 16'h8000, 16'h7FFF};
`else
  localparam logic [15:0] VR   [NV] = '{16'h0008, 16'h7FFF, 16'h8000, 16'hFFFE, 16'h0000, 16'h8000};
`endif
  localparam logic        VO   [NV] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req0 = 1'b0;
    req1 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_vec++;
    if ({st, overflow, result} !== 21'h0) begin
      $display("FAIL reset_state: got st=%b ovf=%b res=%h want all zero", st, overflow, result);
      n_err++;
    end
    rst = 1'b0;
    req1 = 1'b1; a1 = 16'h0003; b1 = 16'h0004; ctrl1 = 1'b0;
    step();
    n_vec++;
    if (st !== 4'b1100) begin
      $display("FAIL reset_pre_grant: got %b want %b", st, 4'b1100);
      n_err++;
    end
    // Async reset mid-cycle, just before the EXEC->DONE edge would have been seen
    @(posedge clk);
    #3 rst = 1'b1;
    req1 = 1'b0;
    #1;
    n_vec++;
    if ({st, overflow, result} !== 21'h0) begin
      $display("FAIL reset_async: got st=%b ovf=%b res=%h want all zero", st, overflow, result);
      n_err++;
    end
    @(negedge clk);
    rst = 1'b0;
    req0 = 1'b1; a0 = 16'h0001; b0 = 16'h0002; ctrl0 = 1'b0;
    req1 = 1'b1; a1 = 16'h0005; b1 = 16'h0005; ctrl1 = 1'b0;
    step();
    req0 = 1'b0;
    req1 = 1'b0;
    n_vec++;
    if (st !== 4'b1000) begin
      $display("FAIL reset_tie_grant: got %b want %b", st, 4'b1000);
      n_err++;
    end
    step();
    n_vec++;
    if (st !== 4'b1010 || result !== 16'h0003) begin
      $display("FAIL reset_tie_done: got st=%b res=%h want st=1010 res=0003", st, result);
      n_err++;
    end
    step();
  endtask

  task automatic test_arith();
    do_reset();
    for (int i = 0; i < NV; i++) begin
      if (VSEL[i]) begin
        req1 = 1'b1; a1 = VA[i]; b1 = VB[i]; ctrl1 = VC[i];
      end else begin
        req0 = 1'b1; a0 = VA[i]; b0 = VB[i]; ctrl0 = VC[i];
      end
      step();
      n_vec++;
      if (st !== {1'b1, VSEL[i], 2'b00}) begin
        $display("FAIL arith%0d_grant: got %b want %b", i, st, {1'b1, VSEL[i], 2'b00});
        n_err++;
      end
      // Drop request and scramble operands: the latched operation must be unaffected
      req0 = 1'b0; req1 = 1'b0;
      a0 = ~VA[i]; b0 = ~VB[i]; a1 = ~VA[i]; b1 = ~VB[i]; ctrl0 = ~VC[i]; ctrl1 = ~VC[i];
      step();
      n_vec++;
      if (st !== {1'b1, VSEL[i], ~VSEL[i], VSEL[i]} || result !== VR[i]
          || overflow !== VO[i]) begin
        $display("FAIL arith%0d_done: got st=%b res=%h ovf=%b want st=%b res=%h ovf=%b", i, st,
                 result, overflow, {1'b1, VSEL[i], ~VSEL[i], VSEL[i]}, VR[i], VO[i]);
        n_err++;
      end
      step();
      n_vec++;
      if (st !== {1'b0, VSEL[i], 2'b00} || result !== VR[i] || overflow !== VO[i]) begin
        $display("FAIL arith%0d_hold: got st=%b res=%h ovf=%b want st=%b res=%h ovf=%b", i, st,
                 result, overflow, {1'b0, VSEL[i], 2'b00}, VR[i], VO[i]);
        n_err++;
      end
    end
  endtask

  task automatic test_contention();
    logic sel;
    do_reset();
    req0 = 1'b1; a0 = 16'd1;  b0 = 16'd1; ctrl0 = 1'b0;
    req1 = 1'b1; a1 = 16'd10; b1 = 16'd2; ctrl1 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      sel = (k % 2) == 1;
      step();
      n_vec++;
      if (st !== {1'b1, sel, 2'b00}) begin
        $display("FAIL contend%0d_grant: got %b want %b", k, st, {1'b1, sel, 2'b00});
        n_err++;
      end
      step();
      n_vec++;
      if (st !== {1'b1, sel, ~sel, sel} || result !== (sel ? 16'h000C : 16'h0002)) begin
        $display("FAIL contend%0d_done: got st=%b res=%h want st=%b res=%h", k, st, result,
                 {1'b1, sel, ~sel, sel}, sel ? 16'h000C : 16'h0002);
        n_err++;
      end
      step();
      n_vec++;
      if (st !== {1'b0, sel, 2'b00}) begin
        $display("FAIL contend%0d_idle: got %b want %b", k, st, {1'b0, sel, 2'b00});
        n_err++;
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    step();
  endtask

  task automatic test_abort();
    do_reset();
    req1 = 1'b1; a1 = 16'h0100; b1 = 16'h0023; ctrl1 = 1'b0;
    step();
    n_vec++;
    if (st !== 4'b1100) begin
      $display("FAIL abort_grant: got %b want %b", st, 4'b1100);
      n_err++;
    end
    rst = 1'b1;
    req1 = 1'b0;
    #1;
    n_vec++;
    if ({st, overflow, result} !== 21'h0) begin
      $display("FAIL abort_rst: got st=%b ovf=%b res=%h want all zero", st, overflow, result);
      n_err++;
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step();
      n_vec++;
      if (st !== 4'b0000 || result !== 16'h0000) begin
        $display("FAIL abort_quiet%0d: got st=%b res=%h want st=0000 res=0000", k, st, result);
        n_err++;
      end
    end
    req1 = 1'b1; a1 = 16'h0200; b1 = 16'h0011; ctrl1 = 1'b1;
    step();
    req1 = 1'b0;
    n_vec++;
    if (st !== 4'b1100) begin
      $display("FAIL abort_regrant: got %b want %b", st, 4'b1100);
      n_err++;
    end
    step();
    n_vec++;
    if (st !== 4'b1101 || result !== 16'h01EF || overflow !== 1'b0) begin
      $display("FAIL abort_redone: got st=%b res=%h ovf=%b want st=1101 res=01ef ovf=0", st,
               result, overflow);
      n_err++;
    end
    step();
    n_vec++;
    if (st !== 4'b0100) begin
      $display("FAIL abort_reidle: got %b want %b", st, 4'b0100);
      n_err++;
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_contention();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
